// File: rtl/playfield_arbiter_if.sv
// Client bundle of the playfield arbiter: video cell lookup, game request port
// and row-clear control/status, with the arbiter on the slave side.
interface playfield_arbiter_if #(
  parameter int CELL_W = 3
);
  logic              disp_active;
  logic [4:0]        disp_row;
  logic [4:0]        disp_col;
  logic [CELL_W-1:0] disp_data;
  logic              gp_req;
  logic              gp_we;
  logic [4:0]        gp_row;
  logic [4:0]        gp_col;
  logic [CELL_W-1:0] gp_wdata;
  logic              gp_ack;
  logic [CELL_W-1:0] gp_rdata;
  logic              clr_start;
  logic [4:0]        clr_row;
  logic              clr_busy;
  logic              clr_done;
  logic              init_busy;

  modport master (
    output disp_active, disp_row, disp_col, gp_req, gp_we, gp_row, gp_col,
           gp_wdata, clr_start, clr_row,
    input  disp_data, gp_ack, gp_rdata, clr_busy, clr_done, init_busy
  );

  modport slave (
    input  disp_active, disp_row, disp_col, gp_req, gp_we, gp_row, gp_col,
           gp_wdata, clr_start, clr_row,
    output disp_data, gp_ack, gp_rdata, clr_busy, clr_done, init_busy
  );
endinterface

// File: rtl/playfield_arbiter.sv
// Single-ported playfield cell store shared per cycle between the zero-fill
// sweep, video lookups, the row-clear engine and the game port, in that priority.
module playfield_arbiter #(
  parameter int ROWS   = 12,
  parameter int COLS   = 21,
  parameter int CELL_W = 3
) (
  input  logic               clk_25_175,
  input  logic               reset,
  playfield_arbiter_if.slave bus
);
  localparam int            DEPTH     = ROWS * COLS;
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [4:0]    ROWS_L    = 5'(ROWS);
  localparam logic [4:0]    COLS_L    = 5'(COLS);
  localparam logic [4:0]    LAST_COL  = 5'(COLS - 1);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CLR_RD  = 3'd2,
    ST_CLR_WR  = 3'd3,
    ST_CLR_TOP = 3'd4
  } state_e;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [4:0] col);
    logic [15:0] lin;
    lin = 16'(row) * 16'(COLS) + 16'(col);
    return lin[AW-1:0];
  endfunction

  function automatic logic in_range(input logic [4:0] row, input logic [4:0] col);
    return (row < ROWS_L) && (col < COLS_L);
  endfunction

  logic [CELL_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [AW-1:0]     init_addr_q, init_addr_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [CELL_W-1:0] hold_q, hold_d;
  logic [CELL_W-1:0] disp_data_q, disp_data_d;
  logic              gp_ack_q, gp_ack_d;
  logic [CELL_W-1:0] gp_rdata_q, gp_rdata_d;
  logic              clr_done_q, clr_done_d;

  logic              mem_we_s;
  logic [AW-1:0]     mem_addr_s;
  logic [CELL_W-1:0] mem_wdata_s;
  logic [CELL_W-1:0] rd_cell_s;
  logic              video_s;
  logic              clr_accept_s;

  assign rd_cell_s = mem_q[mem_addr_s];

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    row_d        = row_q;
    col_d        = col_q;
    hold_d       = hold_q;
    disp_data_d  = disp_data_q;
    gp_ack_d     = 1'b0;
    gp_rdata_d   = gp_rdata_q;
    clr_done_d   = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;
    video_s      = bus.disp_active && (state_q != ST_INIT);
    clr_accept_s = (state_q == ST_IDLE) && bus.clr_start;

    // Latching a clear needs no store access, so it happens even while video owns the slot.
    if (clr_accept_s) begin
      if (bus.clr_row < ROWS_L) begin
        row_d   = bus.clr_row;
        col_d   = 5'd0;
        state_d = (bus.clr_row == 5'd0) ? ST_CLR_TOP : ST_CLR_RD;
      end else begin
        clr_done_d = 1'b1;
      end
    end else begin
      clr_done_d = 1'b0;
    end

    if (state_q == ST_INIT) begin
      mem_we_s   = 1'b1;
      mem_addr_s = init_addr_q;
      if (init_addr_q == LAST_ADDR) begin
        init_addr_d = '0;
        state_d     = ST_IDLE;
      end else begin
        init_addr_d = init_addr_q + 1'b1;
      end
    end else if (video_s) begin
      mem_addr_s  = cell_addr(bus.disp_row, bus.disp_col);
      disp_data_d = in_range(bus.disp_row, bus.disp_col) ? rd_cell_s : '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // gp_ack_q blocks re-serving a request still held during its ack cycle.
          if (bus.gp_req && !gp_ack_q && !clr_accept_s) begin
            gp_ack_d   = 1'b1;
            mem_addr_s = cell_addr(bus.gp_row, bus.gp_col);
            if (bus.gp_we) begin
              mem_we_s    = in_range(bus.gp_row, bus.gp_col);
              mem_wdata_s = bus.gp_wdata;
            end else begin
              gp_rdata_d = in_range(bus.gp_row, bus.gp_col) ? rd_cell_s : '0;
            end
          end else begin
            gp_ack_d = 1'b0;
          end
        end
        ST_CLR_RD: begin
          mem_addr_s = cell_addr(row_q - 5'd1, col_q);
          hold_d     = rd_cell_s;
          state_d    = ST_CLR_WR;
        end
        ST_CLR_WR: begin
          mem_we_s    = 1'b1;
          mem_addr_s  = cell_addr(row_q, col_q);
          mem_wdata_s = hold_q;
          if (col_q == LAST_COL) begin
            col_d   = 5'd0;
            row_d   = row_q - 5'd1;
            state_d = (row_q == 5'd1) ? ST_CLR_TOP : ST_CLR_RD;
          end else begin
            col_d   = col_q + 5'd1;
            state_d = ST_CLR_RD;
          end
        end
        ST_CLR_TOP: begin
          mem_we_s   = 1'b1;
          mem_addr_s = cell_addr(5'd0, col_q);
          if (col_q == LAST_COL) begin
            col_d      = 5'd0;
            clr_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      row_q       <= 5'd0;
      col_q       <= 5'd0;
      hold_q      <= '0;
      disp_data_q <= '0;
      gp_ack_q    <= 1'b0;
      gp_rdata_q  <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      hold_q      <= hold_d;
      disp_data_q <= disp_data_d;
      gp_ack_q    <= gp_ack_d;
      gp_rdata_q  <= gp_rdata_d;
      clr_done_q  <= clr_done_d;
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign bus.disp_data = disp_data_q;
  assign bus.gp_ack    = gp_ack_q;
  assign bus.gp_rdata  = gp_rdata_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.clr_busy  = (state_q == ST_CLR_RD) || (state_q == ST_CLR_WR) || (state_q == ST_CLR_TOP);
  assign bus.init_busy = (state_q == ST_INIT);
endmodule

// File: doc/playfield_arbiter.md
# playfield_arbiter

Owns the single-ported playfield cell store (ROWS × COLS cells, 3-bit block type per cell) and shares its one access slot per clock between three clients: the video path (the pixel pipeline's cell lookup), the game-logic request port, and a built-in row-clear engine that shifts rows down. It also zero-fills the store after reset. It sits between the tetris game FSM and the pixel generator, replacing a free-running board array.

## Interface
Parameters:
- ROWS, 12, playfield rows (vertical blocks)
- COLS, 21, playfield columns (horizontal blocks)
- CELL_W, 3, bits per cell (block type; 0 = empty)

Ports:
- clk_25_175  in  1  pixel clock
- reset  in  1  synchronous, active-low
- disp_active  in  1  video requests a read this cycle
- disp_row  in  5  video cell row
- disp_col  in  5  video cell column
- disp_data  out  CELL_W  registered video read data
- gp_req  in  1  game request, held until gp_ack
- gp_we  in  1  1 = write, 0 = read; stable while gp_req
- gp_row  in  5  game cell row
- gp_col  in  5  game cell column
- gp_wdata  in  CELL_W  game write data
- gp_ack  out  1  one-cycle completion pulse
- gp_rdata  out  CELL_W  game read data, valid with gp_ack
- clr_start  in  1  pulse: clear row clr_row
- clr_row  in  5  row to remove
- clr_busy  out  1  clear engine running
- clr_done  out  1  one-cycle pulse when clear finishes
- init_busy  out  1  post-reset zero-fill running

## Operation
- Store: one access (read or write) per cycle; synchronous read, data available the next cycle.
- Slot priority per cycle: INIT sweep > video (disp_active) > clear engine > game port.
- States: INIT, IDLE, CLR_RD, CLR_WR, CLR_TOP.
- INIT: entered on reset; writes 0 to every cell, row-major, one per cycle (ROWS*COLS cycles, 252 default); init_busy=1; no other client served; then IDLE.
- IDLE: game port served when slot free, gp_req=1 and gp_ack=0 in this cycle (no double service of a held request).
- clr_start in IDLE with clr_row < ROWS: latch row r, clr_busy=1; clr_start ignored when busy or in INIT.
- clr_start with clr_row >= ROWS: no store access, clr_done pulses next cycle, clr_busy stays 0.
- Clear sequence: for row r down to 1, for each col 0..COLS-1: CLR_RD reads (row-1, col) → hold register; CLR_WR writes hold to (row, col). Then CLR_TOP writes 0 to row 0, cols 0..COLS-1. Then IDLE.
- Any clear step waits in place while video holds the slot; hold register keeps read data across stalls.
- Game port fully blocked while clr_busy=1 (request waits, no ack).
- Out-of-range address (row >= ROWS or col >= COLS): video read returns 0; game write is dropped but acked; game read returns 0 with ack.
- disp_data holds its last value when disp_active=0.

## Timing
- Reset values: disp_data=0, gp_ack=0, gp_rdata=0, clr_busy=0, clr_done=0, init_busy=1; store re-zeroed via INIT.
- Reset mid-clear or mid-request: clear abandoned, pending request not acked, INIT restarts.
- Video: disp_active at cycle t → disp_data valid cycle t+1, always (after INIT).
- Game: granted at cycle t → gp_ack=1 and gp_rdata valid at t+1; earliest next grant t+2.
- Clear of row r with no stalls: 2·r·COLS + COLS cycles of store access; clr_done pulses the cycle after the final row-0 write, clr_busy falls that same cycle.
- Simultaneous clr_start and gp_req in IDLE: clear wins; request served after clr_done.

## Test plan
- Reset release → init_busy high 252 cycles; then disp read of (11,20) returns 0 one cycle later.
- Game write (3,5)=6, then game read (3,5) → gp_ack pulses one cycle after each grant, gp_rdata=6.
- Hold disp_active=1 continuously with gp_req=1 → no gp_ack; drop disp_active → gp_ack next cycle.
- Fill row 4=2, row 5=7, row 3=1; clr_start, clr_row=5 → after 2·5·21+21=231 cycles clr_done; row 5=2, row 4=1, row 0=0.
- Clear with disp_active toggling every other cycle → final board identical to unstalled case; clr_busy longer.
- Game write to (12,0) → acked, store unchanged; clr_row=15 → clr_done next cycle, clr_busy never asserted.
